pkt_bufid_dispatcher: RTL and testbench
=======================================

PKT_BUFID_DISPATCHER -- requirements
Module: pkt_bufid_dispatcher

Interface
REQ-001 Parameter PORT_NUM, default 4: number of input-port requesters; this release supports only 4.
REQ-002 Parameter BUFID_W, default 9: buffer-id width.
REQ-003 Port clk_sys, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port iv_free_bufid, input, BUFID_W: head entry of the show-ahead free-bufid FIFO.
REQ-006 Port i_free_bufid_empty, input, 1: free-bufid FIFO empty.
REQ-007 Port iv_free_bufid_fifo_rdusedw, input, 9: FIFO occupancy.
REQ-008 Port o_free_bufid_rd, output, 1: single-cycle pop of the FIFO head.
REQ-009 Port iv_bufid_req, input, PORT_NUM: per-port request level, high while the port's bufid holding register is empty.
REQ-010 Port iv_low_prio_mask, input, PORT_NUM: ports that are ineligible while the pool is below the reserve.
REQ-011 Port iv_reserve_threshold, input, 9: pool reserve level.
REQ-012 Port ov_pkt_bufid_wr, output, PORT_NUM: one-hot bufid write strobe.
REQ-013 Port ov_pkt_bufid, output, BUFID_W: shared bufid bus.
REQ-014 Port iv_pkt_bufid_ack, input, PORT_NUM: per-port acceptance.
REQ-015 Port o_starve_pulse, output, 1: rising edge of the starvation condition.
REQ-016 Port ov_dispatch_state, output, 2: current FSM state, for debug.

Function
REQ-017 The FSM SHALL have three states: IDLE=2'b00, OFFER=2'b01, DRAIN=2'b10.
REQ-018 A port is eligible when iv_bufid_req[p]=1, and additionally iv_low_prio_mask[p]=0 whenever iv_free_bufid_fifo_rdusedw < iv_reserve_threshold.
REQ-019 In IDLE, with at least one port eligible and i_free_bufid_empty=0, the block SHALL do all of the following in the same cycle:
- pick the first eligible port in round-robin order starting from last_grant+1 (mod 4);
- pulse o_free_bufid_rd;
- latch iv_free_bufid and the grant index;
- go to OFFER.
REQ-020 In OFFER, ov_pkt_bufid_wr SHALL be one-hot at the grant index and ov_pkt_bufid SHALL be the latched bufid, both held until iv_pkt_bufid_ack at the grant index is high.
REQ-021 On an ack in OFFER, the block SHALL update last_grant to the grant index and go to DRAIN; the strobe SHALL be low from the next cycle onward.
REQ-022 DRAIN SHALL last exactly one cycle, then the FSM SHALL return to IDLE, so that the port's request level has time to fall.
REQ-023 Latency: request seen in IDLE in cycle N, then rd pulse in cycle N, wr high in N+1; ack in N+1 gives DRAIN in N+2, IDLE in N+3; earliest next rd is N+3.
REQ-024 If the granted port drops its request during OFFER, the offer SHALL still be held until acked; a popped bufid is never discarded or re-queued.
REQ-025 Acks from non-granted ports, and acks outside OFFER, SHALL be ignored.
REQ-026 o_free_bufid_rd SHALL never assert while i_free_bufid_empty=1, and at most once per grant.
REQ-027 Starvation condition: IDLE, any bit of iv_bufid_req high, and either the FIFO is empty or no port is eligible because of the reserve mask. o_starve_pulse SHALL be one cycle on the 0-to-1 transition of this condition.
REQ-028 When the occupancy and threshold are equal, the pool counts as not below the reserve (strict less-than comparison).
REQ-029 last_grant SHALL wrap from 3 to 0.

Reset
REQ-030 While reset=1, at the next edge:
- state=IDLE and last_grant=3 (so port 0 is served first);
- all outputs are 0 (ov_pkt_bufid=0, ov_dispatch_state=2'b00);
- the starvation-edge register is 0.
REQ-031 Reset during OFFER SHALL abandon the latched bufid; the free-bufid pool is reinitialised by the same reset.

Structure
REQ-032 Package bufid_dispatch_pkg SHALL hold PORT_NUM, BUFID_W and the state encodings.
REQ-033 The round-robin picker SHALL be the sub-module rr_arbiter (inputs: request vector, last_grant; outputs: grant index, valid). It is purely combinational; the FSM and all registers stay in pkt_bufid_dispatcher.

Verification
REQ-034 Single request: FIFO head=9'h005, req=4'b0010 at N, ack at N+2. Required: rd in N; wr=4'b0010 with bufid 5 during N+1..N+2; strobe low at N+3.
REQ-035 Fairness: all four ports request continuously, acks are immediate, FIFO holds 1,2,3,4,5. Required: grants to ports 0,1,2,3,0 with bufids 1..5.
REQ-036 Reserve: rdusedw=3, threshold=4, mask=4'b1100, req=4'b1100. Required: no rd and one o_starve_pulse. Then raise rdusedw to 4; the next grant goes to port 2.
REQ-037 Empty FIFO: req=4'b0001 with empty=1 for 10 cycles. Required: no rd and a single starve pulse. When empty falls, the grant follows in the same cycle.
REQ-038 Request withdrawn: port 1 drops req during OFFER and acks 5 cycles later. Required: wr held all 5 cycles and the same bufid delivered.
REQ-039 Reset in OFFER: assert reset for 1 cycle. Required: wr=0 the next cycle, state IDLE, and the first grant after reset goes to port 0.

Source files
------------

// File: rtl/bufid_dispatch_pkg.sv
//------------------------------------------------------------------------------
// Module      : bufid_dispatch_pkg
// Description : Shared sizes and FSM state encodings for the bufid dispatcher.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bufid_dispatch_pkg;

  localparam int PORT_NUM = 4;
  localparam int BUFID_W  = 9;
  localparam int CNT_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OFFER = 2'b01,
    ST_DRAIN = 2'b10
  } dispatch_state_e;

endpackage

`default_nettype wire

// File: rtl/pkt_bufid_dispatcher_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter
// Description : Combinational round-robin picker, search starts at last+1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int PORT_NUM = 4,
  parameter int IDX_W    = $clog2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] i_req,
  input  logic [IDX_W-1:0]    i_last_grant,
  output logic [IDX_W-1:0]    o_grant_idx,
  output logic                o_valid
);

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    int cand;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    for (int k = PORT_NUM; k >= 1; k--) begin
      cand = (int'(i_last_grant) + k) % PORT_NUM;
      if (i_req[cand]) begin
        o_grant_idx = IDX_W'(cand);
        o_valid     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pkt_bufid_dispatcher.sv
//------------------------------------------------------------------------------
// Module      : pkt_bufid_dispatcher
// Description : Pops free buffer ids and offers them round-robin to input ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pkt_bufid_dispatcher #(
  parameter int PORT_NUM = bufid_dispatch_pkg::PORT_NUM,
  parameter int BUFID_W  = bufid_dispatch_pkg::BUFID_W
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [BUFID_W-1:0]  iv_free_bufid,
  input  logic                i_free_bufid_empty,
  input  logic [8:0]          iv_free_bufid_fifo_rdusedw,
  output logic                o_free_bufid_rd,
  input  logic [PORT_NUM-1:0] iv_bufid_req,
  input  logic [PORT_NUM-1:0] iv_low_prio_mask,
  input  logic [8:0]          iv_reserve_threshold,
  output logic [PORT_NUM-1:0] ov_pkt_bufid_wr,
  output logic [BUFID_W-1:0]  ov_pkt_bufid,
  input  logic [PORT_NUM-1:0] iv_pkt_bufid_ack,
  output logic                o_starve_pulse,
  output logic [1:0]          ov_dispatch_state
);

  import bufid_dispatch_pkg::*;

  localparam int IDX_W = $clog2(PORT_NUM);

  dispatch_state_e     state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [BUFID_W-1:0]  bufid_q, bufid_d;
  logic                starve_q, starve_d;

  logic                below_reserve;
  logic [PORT_NUM-1:0] eligible;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                rd;
  logic                starve_cond;

  always_comb begin
    below_reserve = iv_free_bufid_fifo_rdusedw < iv_reserve_threshold;
    eligible      = iv_bufid_req & ~(below_reserve ? iv_low_prio_mask : '0);
  end

  rr_arbiter #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_rr_arbiter (
    .i_req        (eligible),
    .i_last_grant (last_grant_q),
    .o_grant_idx  (arb_idx),
    .o_valid      (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    bufid_d      = bufid_q;
    rd           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid && !i_free_bufid_empty) begin
          rd      = 1'b1;
          bufid_d = iv_free_bufid;
          grant_d = arb_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (iv_pkt_bufid_ack[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_DRAIN;
        end
      end
      // One dead cycle lets the served port's request level fall.
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_cond = (state_q == ST_IDLE) && (|iv_bufid_req) &&
                  (i_free_bufid_empty || !arb_valid);
    starve_d    = starve_cond;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(PORT_NUM - 1);
      grant_q      <= '0;
      bufid_q      <= '0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      bufid_q      <= bufid_d;
      starve_q     <= starve_d;
    end
  end

  always_comb begin
    o_free_bufid_rd   = rd & ~reset;
    o_starve_pulse    = starve_cond & ~starve_q & ~reset;
    ov_pkt_bufid_wr   = (state_q == ST_OFFER) ?
                        ({{(PORT_NUM-1){1'b0}}, 1'b1} << grant_q) : '0;
    ov_pkt_bufid      = (state_q == ST_OFFER) ? bufid_q : '0;
    ov_dispatch_state = state_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pkt_bufid_dispatcher.sv
//------------------------------------------------------------------------------
// Module      : tb_pkt_bufid_dispatcher
// Description : Directed self-checking bench for pkt_bufid_dispatcher.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pkt_bufid_dispatcher;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [8:0] free_bufid;
  logic       free_empty;
  logic [8:0] rdusedw;
  logic [8:0] thr;
  logic [3:0] req;
  logic [3:0] mask;
  logic [3:0] ack;
  logic       rd_o;
  logic [3:0] wr_o;
  logic [8:0] bufid_o;
  logic       starve_o;
  logic [1:0] state_o;

  logic [8:0] fifo[$];
  logic       force_empty;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk_sys = ~clk_sys;

  pkt_bufid_dispatcher dut (
    .clk_sys                    (clk_sys),
    .reset                      (reset),
    .iv_free_bufid              (free_bufid),
    .i_free_bufid_empty         (free_empty),
    .iv_free_bufid_fifo_rdusedw (rdusedw),
    .o_free_bufid_rd            (rd_o),
    .iv_bufid_req               (req),
    .iv_low_prio_mask           (mask),
    .iv_reserve_threshold       (thr),
    .ov_pkt_bufid_wr            (wr_o),
    .ov_pkt_bufid               (bufid_o),
    .iv_pkt_bufid_ack           (ack),
    .o_starve_pulse             (starve_o),
    .ov_dispatch_state          (state_o)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    free_empty = force_empty || (fifo.size() == 0);
    free_bufid = (fifo.size() != 0) ? fifo[0] : 9'h0;
    #1;
  endtask

  // The show-ahead FIFO model pops on an edge where rd was high.
  task automatic tick();
    logic rd_seen;
    rd_seen = rd_o;
    @(posedge clk_sys);
    #1;
    if (rd_seen && fifo.size() != 0) void'(fifo.pop_front());
    settle();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ack = '0; mask = '0; force_empty = 1'b0;
    rdusedw = 9'd100; thr = 9'd0;
    fifo.delete();
    settle();
    tick(); tick();
    reset = 1'b0;
    settle();
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_o != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit         ok;
    int         rd_cnt;
    int         st_cnt;
    int         held;
    logic [3:0] exp_wr;

    // Reset state
    do_reset();
    chk_eq("rst_wr", wr_o, 4'b0);
    chk_eq("rst_bufid", bufid_o, 9'h0);
    chk_eq("rst_state", state_o, 2'b00);
    chk_eq("rst_rd", rd_o, 1'b0);
    chk_eq("rst_starve", starve_o, 1'b0);

    // Single request with the ack one cycle late
    fifo.push_back(9'h005);
    req = 4'b0010;
    settle();
    chk_eq("single_rd_N", rd_o, 1'b1);
    tick();
    req = 4'b0000;
    settle();
    chk_eq("single_state_N1", state_o, 2'b01);
    chk_eq("single_wr_N1", wr_o, 4'b0010);
    chk_eq("single_bufid_N1", bufid_o, 9'h005);
    chk_eq("single_rd_N1", rd_o, 1'b0);
    tick();
    ack = 4'b0010;
    settle();
    chk_eq("single_wr_N2", wr_o, 4'b0010);
    chk_eq("single_bufid_N2", bufid_o, 9'h005);
    tick();
    ack = 4'b0000;
    settle();
    chk_eq("single_wr_N3", wr_o, 4'b0000);
    chk_eq("single_state_N3", state_o, 2'b10);
    tick();
    chk_eq("single_state_N4", state_o, 2'b00);

    // Fairness across all four ports
    do_reset();
    for (int b = 1; b <= 5; b++) fifo.push_back(9'(b));
    req = 4'b1111;
    settle();
    for (int k = 0; k < 5; k++) begin
      wait_wr(ok);
      chk_eq("fair_timeout", ok, 1'b1);
      exp_wr = 4'b0001 << (k % 4);
      chk_eq($sformatf("fair_wr_%0d", k), wr_o, exp_wr);
      chk_eq($sformatf("fair_bufid_%0d", k), bufid_o, 32'(k + 1));
      ack = wr_o;
      settle();
      tick();
      ack = 4'b0000;
      settle();
    end
    req = 4'b0000;
    settle();

    // Reserve gating, then release at occupancy == threshold
    do_reset();
    fifo.push_back(9'h007);
    rdusedw = 9'd3; thr = 9'd4; mask = 4'b1100; req = 4'b1100;
    settle();
    rd_cnt = 0; st_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      rd_cnt += int'(rd_o);
      st_cnt += int'(starve_o);
      tick();
    end
    chk_eq("resv_no_rd", rd_cnt, 0);
    chk_eq("resv_one_starve", st_cnt, 1);
    rdusedw = 9'd4;
    settle();
    chk_eq("resv_rd_at_equal", rd_o, 1'b1);
    tick();
    chk_eq("resv_wr", wr_o, 4'b0100);
    chk_eq("resv_bufid", bufid_o, 9'h007);
    ack = 4'b0100;
    settle();
    tick();
    ack = 4'b0000; req = 4'b0000; mask = 4'b0000;
    settle();
    tick();

    // Empty FIFO starvation, then grant on the cycle empty falls
    do_reset();
    fifo.push_back(9'h009);
    force_empty = 1'b1;
    req = 4'b0001;
    settle();
    rd_cnt = 0; st_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rd_cnt += int'(rd_o);
      st_cnt += int'(starve_o);
      tick();
    end
    chk_eq("empty_no_rd", rd_cnt, 0);
    chk_eq("empty_one_starve", st_cnt, 1);
    force_empty = 1'b0;
    settle();
    chk_eq("empty_rd_same_cycle", rd_o, 1'b1);
    tick();
    chk_eq("empty_wr", wr_o, 4'b0001);
    chk_eq("empty_bufid", bufid_o, 9'h009);
    ack = 4'b0001;
    settle();
    tick();
    ack = 4'b0000; req = 4'b0000;
    settle();
    tick();

    // Request withdrawn during OFFER; stray ack from another port ignored
    do_reset();
    fifo.push_back(9'h1AB);
    req = 4'b0010;
    settle();
    wait_wr(ok);
    chk_eq("wdraw_timeout", ok, 1'b1);
    req = 4'b0000;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      ack = (i == 2) ? 4'b0001 : 4'b0000;
      settle();
      if (wr_o == 4'b0010 && bufid_o == 9'h1AB) held++;
      tick();
    end
    chk_eq("wdraw_held", held, 5);
    ack = 4'b0010;
    settle();
    chk_eq("wdraw_wr_at_ack", wr_o, 4'b0010);
    tick();
    ack = 4'b0000;
    settle();
    chk_eq("wdraw_wr_after", wr_o, 4'b0000);
    chk_eq("wdraw_state_drain", state_o, 2'b10);
    tick();

    // Reset while offering to port 2 after port 1 was last served
    do_reset();
    fifo.push_back(9'h021); fifo.push_back(9'h033); fifo.push_back(9'h044);
    req = 4'b0010;
    settle();
    wait_wr(ok);
    ack = 4'b0010;
    settle();
    tick();
    ack = 4'b0000; req = 4'b0100;
    settle();
    wait_wr(ok);
    chk_eq("roff_wr", wr_o, 4'b0100);
    chk_eq("roff_bufid", bufid_o, 9'h033);
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0;
    settle();
    chk_eq("roff_wr_after_rst", wr_o, 4'b0000);
    chk_eq("roff_state_after_rst", state_o, 2'b00);
    req = 4'b1111;
    settle();
    chk_eq("roff_rd", rd_o, 1'b1);
    tick();
    chk_eq("roff_first_grant", wr_o, 4'b0001);
    chk_eq("roff_first_bufid", bufid_o, 9'h044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
